// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: opcodes, FSM states, flag bundle.
// ALU_DIV_EN selects whether DIV/MOD are iterative or treated as illegal.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_LSL = 4'h6, OP_LSR = 4'h7,
    OP_ASR = 4'h8, OP_ROL = 4'h9, OP_ROR = 4'hA, OP_MUL = 4'hB,
    OP_DIV = 4'hC, OP_MOD = 4'hD, OP_IL0 = 4'hE, OP_IL1 = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, ITERA, DONE} state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  function automatic logic is_iterative(alu_op_e op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_multiciclo_if.sv
// Operand/result handshake bundle between register file, ALU and writeback.
interface alu_multiciclo_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] resultado;
  logic             flag_negativo;
  logic             flag_cero;
  logic             flag_overflow;
  logic             flag_carry;

  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, resultado,
           flag_negativo, flag_cero, flag_overflow, flag_carry
  );

  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, resultado,
           flag_negativo, flag_cero, flag_overflow, flag_carry
  );
endinterface

// File: rtl/alu_iterativo.sv
// WIDTH-step engine: shift-add multiplier and restoring divider share hi/lo/count.
// Divider path exists only with ALU_DIV_EN defined.
module alu_iterativo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero,
  output logic             div_zero
);
  localparam int SHW = $clog2(WIDTH);

  logic             busy_q, mul_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q, hi_d, lo_d;
  logic [WIDTH:0]   msum;
`ifdef ALU_DIV_EN
  logic             mod_q;
  logic [WIDTH:0]   shifted;
`endif

  // MUL: hi accumulates, lo shifts out multiplier bits and collects the low product.
  // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_q) begin
      hi_d = msum[WIDTH:1];
      lo_d = {msum[0], lo_q[WIDTH-1:1]};
    end
`ifdef ALU_DIV_EN
    shifted = {hi_q, lo_q[WIDTH-1]};
    if (!mul_q) begin
      if (shifted >= {1'b0, opnd_q}) begin
        hi_d = shifted[WIDTH-1:0] - opnd_q;
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign done       = busy_q && (cnt_q == SHW'(WIDTH - 1));
  assign hi_nonzero = |hi_d;
  // A zero divisor naturally yields all-ones quotient and remainder = a.
  assign div_zero   = (opnd_q == '0);
`ifdef ALU_DIV_EN
  assign result = (mul_q || !mod_q) ? lo_d : hi_d;
`else
  assign result = lo_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef ALU_DIV_EN
      mod_q  <= 1'b0;
`endif
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      mul_q  <= (op == OP_MUL);
      opnd_q <= (op == OP_MUL) ? a : b;
      hi_q   <= '0;
      lo_q   <= (op == OP_MUL) ? b : a;
`ifdef ALU_DIV_EN
      mod_q  <= (op == OP_MOD);
`endif
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_multiciclo.sv
// Registered ALU with valid/ready handshake; single-cycle ops plus WIDTH-cycle MUL
// (and DIV/MOD when ALU_DIV_EN is defined, otherwise those opcodes are illegal).
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_multiciclo_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  state_e           state_q;
  logic [WIDTH-1:0] res_q, res_sc, rol_r, ror_r, eng_res;
  flags_t           flg_q, flg_sc, flg_it;
  logic             it_mul_q, in_ready, accept, start;
  logic             eng_done, eng_hinz, eng_dz, c_sc, v_sc;
  alu_op_e          op;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w, asr_w;

  assign op       = alu_op_e'(bus.alu_control);
  assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign start    = accept && is_iterative(op);

  always_comb begin
    sh    = bus.b[SHW-1:0];
    add_w = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w = {1'b0, bus.a} - {1'b0, bus.b};
    // Extra bit on the far side of each shift catches the last bit shifted out.
    lsl_w = {1'b0, bus.a} << sh;
    lsr_w = {bus.a, 1'b0} >> sh;
    asr_w = $signed({bus.a, 1'b0}) >>> sh;
    rol_r = WIDTH'(({bus.a, bus.a} << sh) >> WIDTH);
    ror_r = WIDTH'({bus.a, bus.a} >> sh);
    res_sc = '0;
    c_sc   = 1'b0;
    v_sc   = 1'b0;
    case (op)
      OP_ADD: begin
        res_sc = add_w[M:0];
        c_sc   = add_w[WIDTH];
        v_sc   = (bus.a[M] == bus.b[M]) && (add_w[M] != bus.a[M]);
      end
      OP_SUB: begin
        res_sc = sub_w[M:0];
        c_sc   = ~sub_w[WIDTH];
        v_sc   = (bus.a[M] != bus.b[M]) && (sub_w[M] != bus.a[M]);
      end
      OP_AND: res_sc = bus.a & bus.b;
      OP_OR:  res_sc = bus.a | bus.b;
      OP_XOR: res_sc = bus.a ^ bus.b;
      OP_NOT: res_sc = ~bus.a;
      OP_LSL: {c_sc, res_sc} = lsl_w;
      OP_LSR: {res_sc, c_sc} = lsr_w;
      OP_ASR: {res_sc, c_sc} = asr_w;
      OP_ROL: begin
        res_sc = rol_r;
        c_sc   = (sh != '0) && rol_r[0];
      end
      OP_ROR: begin
        res_sc = ror_r;
        c_sc   = (sh != '0) && ror_r[M];
      end
      default: v_sc = 1'b1;
    endcase
  end

  assign flg_sc = '{n: res_sc[M], z: (res_sc == '0), v: v_sc, c: c_sc};
  assign flg_it = '{n: eng_res[M], z: (eng_res == '0),
                    v: it_mul_q ? eng_hinz : eng_dz,
                    c: it_mul_q && eng_hinz};

  alu_iterativo #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (bus.a),
    .b         (bus.b),
    .done      (eng_done),
    .result    (eng_res),
    .hi_nonzero(eng_hinz),
    .div_zero  (eng_dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      flg_q    <= '0;
      it_mul_q <= 1'b0;
    end else begin
      case (state_q)
        ITERA: if (eng_done) begin
          state_q <= DONE;
          res_q   <= eng_res;
          flg_q   <= flg_it;
        end
        default: begin
          if (accept) begin
            if (is_iterative(op)) begin
              state_q  <= ITERA;
              it_mul_q <= (op == OP_MUL);
            end else begin
              state_q <= DONE;
              res_q   <= res_sc;
              flg_q   <= flg_sc;
            end
          end else if (state_q == DONE && bus.out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.resultado     = res_q;
  assign bus.flag_negativo = flg_q.n;
  assign bus.flag_cero     = flg_q.z;
  assign bus.flag_overflow = flg_q.v;
  assign bus.flag_carry    = flg_q.c;
endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
Parametrised, registered successor to the team's combinational ALU: same 4-bit ALUControl opcode space and N/Z/V/C flags, generalised to any WIDTH.
Adds a valid/ready handshake on input and output, registered results, and iterative multiply/divide/modulo taking WIDTH cycles.
Sits between the operand register file and the writeback stage of the processor datapath.

Parameters:
WIDTH, 8, operand and result width in bits (>= 4, power of two)
SHW, $clog2(WIDTH), derived; number of low bits of b used as the shift amount

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands and opcode presented
in_ready  out  1  block accepts an operation this cycle
a  in  WIDTH  operand 1
b  in  WIDTH  operand 2
alu_control  in  4  opcode
out_valid  out  1  result and flags valid
out_ready  in  1  consumer takes the result
resultado  out  WIDTH  registered result
flag_negativo, flag_cero, flag_overflow, flag_carry  out  1 each  registered N/Z/V/C

Behaviour:
- Reset: one clock, asynchronous active-low reset. rst_n low forces state=IDLE, out_valid=0, resultado=0, all flags 0, and clears the engine. This applies immediately, including mid-iteration; any in-flight operation is discarded.
- FSM states: IDLE, ITERA, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Acceptance = in_valid & in_ready. Back-to-back issue is allowed when the output is consumed in the same cycle.
- Single-cycle ops: result and flags are registered on the accept edge; state goes to DONE. out_valid is high the next cycle (latency 1).
- Iterative ops (MUL/DIV/MOD): the accept edge loads the engine and enters ITERA. After exactly WIDTH edges, the state is DONE with out_valid high (latency WIDTH).
- DONE: resultado, flags and out_valid are held stable while out_ready=0. Transfer happens on out_valid & out_ready; the block returns to IDLE or takes a new op.
- Opcodes:
  - 0000 ADD
  - 0001 SUB (a-b)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT a
  - 0110 LSL
  - 0111 LSR
  - 1000 ASR
  - 1001 ROL
  - 1010 ROR
  - 1011 MUL (unsigned, low WIDTH bits)
  - 1100 DIV (unsigned quotient)
  - 1101 MOD (unsigned remainder)
  - 1110/1111 illegal
- Flags for all ops: N = resultado[WIDTH-1]; Z = (resultado==0).
- ADD: C = carry out. V = signed overflow.
- SUB: C = 1 when a>=b unsigned (no borrow). V = signed overflow.
- Shifts/rotates: amount = b[SHW-1:0]. C = last bit shifted or rotated out; amount 0 gives C=0. V=0.
- Logic ops: C=V=0.
- MUL: C = V = 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero.
- DIV/MOD with b==0: DIV returns all ones, MOD returns a, V=1, C=0. Latency is still WIDTH.
- Illegal opcode: single-cycle, resultado=0, Z=1, V=1, N=C=0.
- in_valid while busy (ITERA, or DONE without out_ready) is ignored; operands need not be held after acceptance.

Optional Feature:
ALU_DIV_EN. Defined: DIV/MOD are implemented as above. Undefined: the divider is removed from the engine; 1100/1101 behave as illegal opcodes (single-cycle, resultado=0, Z=1, V=1). MUL is unaffected.

Decomposition:
- Package alu_pkg holds:
  - opcode enum (4-bit, values above)
  - FSM state enum
  - packed flags struct {n,z,v,c}
  - function is_iterative(opcode)
- Sub-module alu_iterativo: shift-add multiplier plus restoring divider sharing one WIDTH-step counter.
  - Inputs: start, op, a, b.
  - Outputs: done, result, hi_nonzero, div_zero.
  - The top module holds the FSM, handshake, single-cycle datapath and flag logic.

Test Plan:
- WIDTH=8, a=0xB5, b=0xAB, ADD, out_ready=1 -> 1 cycle later resultado=0x60, N=0 Z=0 C=1 V=1; SUB same operands -> 0x0A, C=1 V=0.
- MUL a=0xB5 b=0xAB -> out_valid exactly 8 edges after accept, resultado=0xE7, N=1 C=1 V=1; in_ready=0 throughout ITERA.
- DIV a=0xB5 b=0x0B -> 0x10, then MOD same operands -> 0x05 with Z=0; DIV a=0x2A b=0x00 -> 0xFF, V=1; MOD b=0 -> 0x2A, V=1.
- Backpressure: AND a=0xF0 b=0x3C with out_ready=0 for 3 cycles -> resultado=0x30 held, in_ready=0, new in_valid ignored; out_ready=1 with a pending ADD -> transfer and accept on the same edge.
- Shifts: LSL a=0x81 b=0x01 -> 0x02, C=1; ASR a=0x80 b=0x03 -> 0xF0, N=1; ROR a=0x01 b=0x09 (amount 1) -> 0x80, C=1; opcode 1111 -> 0x00, Z=1 V=1.
- Reset: assert rst_n=0 during MUL cycle 4 -> out_valid=0 and resultado=0 immediately; after release a new ADD 0x01+0x01 -> 0x02 with latency 1.
